bist_mult_engine: RTL

Parametrised built-in self-test engine for the radix-4 multiplier family. It generates pseudo-random operand pairs from an LFSR and drives them to an external multiplier (the CUT). It compacts the CUT product stream in a MISR, with the CUT pipeline latency compensated by a configurable delay. It then compares the signature against a golden value and reports PASS/FAIL as ASCII. In functional mode the block is a transparent operand mux in front of the multiplier.

---
 rtl/bist_mult_engine.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/bist_mult_engine.sv
// LFSR-driven BIST for an external multiplier with MISR compaction and golden compare.
// Functional path is a zero-latency operand mux. A run takes N_PATTERNS+CUT_LAT+2 cycles from start to done. There is no backpressure.
module bist_mult_engine #(
  parameter int                     WIDTH      = 4,
  parameter int                     N_PATTERNS = 256,
  parameter int                     CUT_LAT    = 1,
  parameter logic [2*WIDTH-1:0]     SEED       = 8'h01,
  parameter logic [2*WIDTH-1:0]     LFSR_TAPS  = 8'hB8,
  parameter logic [2*WIDTH-1:0]     MISR_TAPS  = 8'hB8,
  parameter logic [2*WIDTH-1:0]     GOLDEN     = 8'hDE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 test_mode,
  input  logic                 fault_inj,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  output logic                 op_valid,
  input  logic [2*WIDTH-1:0]   resp,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [2*WIDTH-1:0]   signature,
  output logic [31:0]          result
);

  localparam int P       = 2 * WIDTH;
  localparam int CW      = $clog2(N_PATTERNS + 1);
  localparam int DW      = $clog2(CUT_LAT + 2);
  localparam int DLAST_I = (CUT_LAT > 0) ? CUT_LAT - 1 : 0;
  localparam logic [CW-1:0] LAST   = CW'(N_PATTERNS - 1);
  localparam logic [DW-1:0] DLAST  = DW'(DLAST_I);
  localparam logic [31:0]   STR_PASS = 32'h50415353;
  localparam logic [31:0]   STR_FAIL = 32'h4641494C;

  typedef enum logic [2:0] {IDLE, RUN, DRAIN, CHECK, DONE} state_t;

  state_t          state;
  logic [P-1:0]    lfsr;
  logic [P-1:0]    misr;
  logic [CW-1:0]   cnt;
  logic [DW-1:0]   dcnt;
  logic            dvld;
  logic [P-1:0]    lfsr_nxt;
  logic [P-1:0]    misr_nxt;
  logic            go;
  logic            abrt;

  assign lfsr_nxt = {lfsr[P-2:0], ^(lfsr & LFSR_TAPS)};
  assign misr_nxt = {misr[P-2:0], ^(misr & MISR_TAPS)} ^ (fault_inj ? ~resp : resp);

  // op_valid is a registered decode of RUN, so the mux never sees resp
  assign op_a      = op_valid ? lfsr[P-1:WIDTH] : a_in;
  assign op_b      = op_valid ? lfsr[WIDTH-1:0] : b_in;
  assign signature = misr;

  assign go   = start && test_mode && (state == IDLE || state == DONE);
  assign abrt = !test_mode && (state == RUN || state == DRAIN || state == CHECK);

  generate
    if (CUT_LAT == 0) begin : g_nolat
      assign dvld = op_valid;
    end else begin : g_lat
      logic [CUT_LAT-1:0] vdly;
      always_ff @(posedge clk) begin
        if (rst || state == IDLE)
          vdly <= '0;
        else
          vdly <= CUT_LAT'({vdly, op_valid});
      end
      assign dvld = vdly[CUT_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lfsr     <= SEED;
      misr     <= '0;
      cnt      <= '0;
      dcnt     <= '0;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      result   <= '0;
    end else begin
      if (dvld)
        misr <= misr_nxt;

      case (state)
        IDLE: begin
          lfsr <= SEED;
          misr <= '0;
          cnt  <= '0;
          dcnt <= '0;
        end
        RUN: begin
          lfsr <= lfsr_nxt;
          cnt  <= cnt + 1'b1;
          if (cnt == LAST) begin
            op_valid <= 1'b0;
            state    <= (CUT_LAT == 0) ? CHECK : DRAIN;
          end
        end
        DRAIN: begin
          if (dcnt == DLAST)
            state <= CHECK;
          else
            dcnt <= dcnt + 1'b1;
        end
        CHECK: begin
          pass   <= (misr == GOLDEN);
          result <= (misr == GOLDEN) ? STR_PASS : STR_FAIL;
          busy   <= 1'b0;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          if (!test_mode) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      // launch and abort override whatever the state branch scheduled
      if (go) begin
        state    <= RUN;
        lfsr     <= SEED;
        misr     <= '0;
        cnt      <= '0;
        dcnt     <= '0;
        op_valid <= 1'b1;
        busy     <= 1'b1;
        done     <= 1'b0;
        pass     <= 1'b0;
        result   <= '0;
      end else if (abrt) begin
        state    <= IDLE;
        op_valid <= 1'b0;
        busy     <= 1'b0;
        done     <= 1'b0;
        pass     <= 1'b0;
        result   <= '0;
      end
    end
  end

endmodule
